// File: rtl/kernel_nios2_qsys_0_mult_seq.sv
// Sequential DATA_W x DATA_W multiplier for MUL/MULXUU/MULXSS/MULXSU using one PART_W x PART_W multiplier.
// Optional KERNEL_NIOS2_MUL_EARLY_OUT_EN: MUL skips chunk pairs that only feed the upper half.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MAC   | one unsigned chunk-pair multiply-accumulate per cycle
// FIX   | signed correction of the upper half, result register loaded
// DONE  | result presented, waiting for out_ready
module kernel_nios2_qsys_0_mult_seq #(
    parameter int DATA_W = 32,
    parameter int PART_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result
);
    localparam int K     = DATA_W / PART_W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int ACC_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    typedef enum logic [1:0] {IDLE, MAC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [1:0]          op_q;
    logic [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]    i_q, j_q;
    logic [IDX_W-1:0]    j_last;
    logic                last_pair;
    logic                accept;
    logic [PART_W-1:0]   a_chunk, b_chunk;
    logic [2*PART_W-1:0] prod;
    logic [ACC_W-1:0]    prod_sh;
    logic [DATA_W-1:0]   hi_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid && !reset) state_nxt = MAC;
            end
            MAC:  if (last_pair) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Low-half product only needs pairs with i+j < K, so MUL ends each row early.
`ifdef KERNEL_NIOS2_MUL_EARLY_OUT_EN
    assign j_last = (op_q == 2'd0) ? (LAST - i_q) : LAST;
`else
    assign j_last = LAST;
`endif
    assign last_pair = (i_q == LAST) && (j_q == j_last);

    always_comb begin
        a_chunk = a_q[int'(i_q) * PART_W +: PART_W];
        b_chunk = b_q[int'(j_q) * PART_W +: PART_W];
        prod    = a_chunk * b_chunk;
        prod_sh = ACC_W'(prod) << (PART_W * (int'(i_q) + int'(j_q)));
    end

    // Two's-complement operands contribute -2^W * other to the full product; only hi is affected.
    always_comb begin
        hi_fix = acc[ACC_W-1:DATA_W];
        if (op_q == 2'd2) begin
            if (a_q[DATA_W-1]) hi_fix = hi_fix - b_q;
            if (b_q[DATA_W-1]) hi_fix = hi_fix - a_q;
        end else if (op_q == 2'd3) begin
            if (a_q[DATA_W-1]) hi_fix = hi_fix - b_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= src1;
                        b_q  <= src2;
                        op_q <= op;
                        acc  <= '0;
                        i_q  <= '0;
                        j_q  <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_sh;
                    if (j_q == j_last) begin
                        j_q <= '0;
                        i_q <= i_q + IDX_W'(1);
                    end else begin
                        j_q <= j_q + IDX_W'(1);
                    end
                end
                FIX:  result <= (op_q == 2'd0) ? acc[DATA_W-1:0] : hi_fix;
                DONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_nios2_qsys_0_mult_seq.sv
// Scoreboard bench for the sequential multiplier: a K=2 (32/16) and a K=4 (64/16) instance.
module tb_kernel_nios2_qsys_0_mult_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, r32;
    logic        iv64, ir64, ov64, or64;
    logic [1:0]  op64;
    logic [63:0] a64, b64, r64;

    logic [63:0] q32[$];
    logic [63:0] q64[$];
    int n_chk  = 0;
    int n_pass = 0;

    kernel_nios2_qsys_0_mult_seq #(.DATA_W(32), .PART_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .src1(a32), .src2(b32), .out_valid(ov32), .out_ready(or32), .result(r32));

    kernel_nios2_qsys_0_mult_seq #(.DATA_W(64), .PART_W(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .op(op64),
        .src1(a64), .src2(b64), .out_valid(ov64), .out_ready(or64), .result(r64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ax, bx, p, m;
        m  = (128'd1 << w) - 128'd1;
        ax = {64'b0, a} & m;
        bx = {64'b0, b} & m;
        if ((o == 2'd2 || o == 2'd3) && a[w-1]) ax = ax | ~m;
        if (o == 2'd2 && b[w-1]) bx = bx | ~m;
        p = ax * bx;
        return (o == 2'd0) ? 64'(p & m) : 64'((p >> w) & m);
    endfunction

    // Edges counted from the accept edge (inclusive) to the edge that raises out_valid.
    function automatic int lat(input int k, input logic [1:0] o);
`ifdef KERNEL_NIOS2_MUL_EARLY_OUT_EN
        return (o == 2'd0) ? k * (k + 1) / 2 + 2 : k * k + 2;
`else
        return (o == 2'd0) ? k * k + 2 : k * k + 2;
`endif
    endfunction

    task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit hold);
        int n;
        logic [63:0] e;
        q32.push_back({32'b0, exp});
        or32 = !hold;
        op32 = o; a32 = a; b32 = b; iv32 = 1'b1;
        n = 0;
        while (!ir32 && n < 50) begin @(negedge clk); n++; end
        check("accept32", ir32, 1);
        @(negedge clk);
        iv32 = 1'b0;
        n = 1;
        while (!ov32 && n < 100) begin @(negedge clk); n++; end
        check("latency32", n, lat(2, o));
        e = q32.pop_front();
        check("result32", r32, e);
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                iv32 = c[0];
                a32  = ~a32;
                @(negedge clk);
                check("hold_valid", ov32, 1);
                check("hold_result", r32, e);
                check("hold_ready", ir32, 0);
            end
            iv32 = 1'b0;
            or32 = 1'b1;
        end
        @(negedge clk);
        check("valid_drop32", ov32, 0);
        check("idle_ready32", ir32, 1);
        check("result_kept32", r32, e);
    endtask

    task automatic run64(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
        int n;
        logic [63:0] e;
        q64.push_back(exp);
        or64 = 1'b1;
        op64 = o; a64 = a; b64 = b; iv64 = 1'b1;
        n = 0;
        while (!ir64 && n < 50) begin @(negedge clk); n++; end
        check("accept64", ir64, 1);
        @(negedge clk);
        iv64 = 1'b0;
        n = 1;
        while (!ov64 && n < 100) begin @(negedge clk); n++; end
        check("latency64", n, lat(4, o));
        e = q64.pop_front();
        check("result64", r64, e);
        @(negedge clk);
        check("valid_drop64", ov64, 0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] a_w, b_w;
        int n;
        reset = 1'b1;
        iv32 = 1'b0; or32 = 1'b1; op32 = '0; a32 = '0; b32 = '0;
        iv64 = 1'b0; or64 = 1'b1; op64 = '0; a64 = '0; b64 = '0;
        #1;
        check("rst_valid", ov32, 0);
        check("rst_result", r32, 0);
        check("rst_ready", ir32, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", ir32, 1);
        @(negedge clk);

        run32(2'd0, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0);
        run32(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run32(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run32(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run32(2'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run32(2'd3, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
        for (int t = 0; t < 8; t++) begin
            o = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            run32(o, a, b, 32'(ref_mul(32, o, {32'b0, a}, {32'b0, b})), 1'b0);
        end
        run32(2'd1, 32'h1234_5678, 32'h9ABC_DEF0,
              32'(ref_mul(32, 2'd1, 64'h1234_5678, 64'h9ABC_DEF0)), 1'b1);

        // Abort in the second MAC cycle; the previous nonzero result must be cleared.
        op32 = 2'd0; a32 = 32'd100; b32 = 32'd200; iv32 = 1'b1;
        n = 0;
        while (!ir32 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        iv32 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_valid", ov32, 0);
        check("abort_result", r32, 0);
        check("abort_ready", ir32, 0);
        @(negedge clk);
        reset = 1'b0;
        run32(2'd0, 32'd7, 32'd6, 32'h0000_002A, 1'b0);

        run64(2'd0, 64'h0000_0000_0001_0003, 64'd5, 64'h0000_0000_0005_000F);
        run64(2'd1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        run64(2'd2, '1, '1, 64'h0);
        run64(2'd3, '1, '1, '1);
        run64(2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        run64(2'd3, 64'h8000_0000_0000_0000, 64'd2, '1);
        for (int t = 0; t < 6; t++) begin
            o = 2'($urandom_range(0, 3));
            a_w = {$urandom, $urandom}; b_w = {$urandom, $urandom};
            run64(o, a_w, b_w, ref_mul(64, o, a_w, b_w));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
